csa_seq_adder: RTL and testbench

Multi-cycle wide adder controller that sequences a single shared 5-bit carry-select slice across a WIDTH-bit operand pair, one slice per clock, least-significant slice first. It sits between an operand producer and a result consumer and uses valid/ready handshakes on both sides. It lets a wide addition reuse the 5-bit CSA datapath at a cost of WIDTH/5 cycles per operation.

---
 rtl/csa_seq_adder.sv | 120 ++++++++++++
 tb/tb_csa_seq_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_adder.sv
// Multi-cycle WIDTH-bit adder that walks one shared 5-bit carry-select slice from LSB to MSB.
// Optional subtract mode is built when CSA_SEQ_SUB_EN is defined (adds input i_sub).
module csa_seq_adder #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_SEQ_SUB_EN
    ,
    input  logic             i_sub
`endif
);

    localparam int NSLICE = WIDTH / 5;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % 5) != 0 || WIDTH < 5) begin : g_bad_width
        $error("csa_seq_adder: WIDTH must be a positive multiple of 5");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // o_ready/o_valid are pure decodes of the state register and never look at i_valid/i_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [KW-1:0]   k;
    logic            carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]      a_sl;
    logic [4:0]      b_sl;
    logic [5:0]      s0;
    logic [5:0]      s1;
    logic [5:0]      sel;
    logic            accept;
    logic            last;
    logic            sub_mode;

`ifdef CSA_SEQ_SUB_EN
    assign sub_mode = i_sub;
`else
    assign sub_mode = 1'b0;
`endif

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign accept  = o_ready && i_valid;
    assign last    = (k == KW'(NSLICE - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The shared slice: both carry candidates are formed, the carry register picks one.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (k == KW'(i)) begin
                a_sl = a_q[i*5 +: 5];
                b_sl = b_q[i*5 +: 5];
            end
        end
        s0  = {1'b0, a_sl} + {1'b0, b_sl};
        s1  = s0 + 6'd1;
        sel = carry ? s1 : s0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                a_q   <= i_add_term1;
                b_q   <= sub_mode ? ~i_add_term2 : i_add_term2;
                carry <= sub_mode;
                k     <= '0;
            end else if (state == RUN) begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (k == KW'(i)) sum[i*5 +: 5] <= sel[4:0];
                end
                carry <= sel[5];
                if (last) begin
                    cout <= sel[5];
                    k    <= '0;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder: directed corner cases plus random operations
// compared against an arithmetic reference; subtract cases run when CSA_SEQ_SUB_EN is defined.
module tb_csa_seq_adder;

    localparam int WIDTH  = 20;
    localparam int NSLICE = WIDTH / 5;
`ifdef CSA_SEQ_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_add_term1 = '0;
    logic [WIDTH-1:0] i_add_term2 = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sub_drv = 1'b0;

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH:0]   exp_q[$];

    csa_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .sum         (sum),
        .cout        (cout)
`ifdef CSA_SEQ_SUB_EN
        ,
        .i_sub       (sub_drv)
`endif
    );

    // Clock and reset-free free-running clock
    always #5 clk = ~clk;

    // Scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned arithmetic on wide integers; cout is bit WIDTH of A+B, or no-borrow for A-B.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic sub);
        longint av;
        longint bv;
        longint r;
        logic   c;
        av = longint'(a);
        bv = longint'(b);
        if (sub) begin
            r = (av - bv) & ((64'd1 << WIDTH) - 1);
            c = (av >= bv);
        end else begin
            r = (av + bv) & ((64'd1 << WIDTH) - 1);
            c = ((av + bv) >= (64'd1 << WIDTH));
        end
        return {c, r[WIDTH-1:0]};
    endfunction

    // Driver: one full operation, including latency, busy, backpressure and handshake checks.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                         input bit poke, input int hold);
        logic [WIDTH:0] e;
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        i_add_term1 = a;
        i_add_term2 = b;
        sub_drv     = sub;
        i_valid     = 1'b1;
        exp_q.push_back(model(a, b, sub));
        @(posedge clk); #1;
        i_valid     = 1'b0;
        i_add_term1 = WIDTH'($urandom);
        i_add_term2 = WIDTH'($urandom);
        sub_drv     = 1'($urandom);
        for (int n = 1; n <= NSLICE; n++) begin
            if (poke && n == 1) begin
                i_valid     = 1'b1;
                i_add_term1 = WIDTH'(1);
                i_add_term2 = WIDTH'(1);
                chk("busy_ready", 32'(o_ready), 32'd0);
            end
            @(posedge clk); #1;
            i_valid = 1'b0;
            if (n < NSLICE) begin
                chk("latency_no_valid", 32'(o_valid), 32'd0);
                chk("run_ready", 32'(o_ready), 32'd0);
            end else begin
                chk("latency_valid", 32'(o_valid), 32'd1);
            end
        end
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e[WIDTH-1:0]));
        chk("cout", 32'(cout), 32'(e[WIDTH]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(e[WIDTH-1:0]));
            chk("hold_cout", 32'(cout), 32'(e[WIDTH]));
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("valid_drop", 32'(o_valid), 32'd0);
        chk("ready_after", 32'(o_ready), 32'd1);
        chk("sum_kept", 32'(sum), 32'(e[WIDTH-1:0]));
    endtask

    initial begin
        // Reset
        #1;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Full carry ripple, no carry, backpressure, busy poke
        do_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 0);
        do_op(20'h12345, 20'h54321, 1'b0, 1'b0, 0);
        do_op(20'hABCDE, 20'h98765, 1'b0, 1'b0, 5);
        do_op(20'h0F0F0, 20'h01010, 1'b0, 1'b1, 1);
        do_op(20'hFFFFF, 20'hFFFFF, 1'b0, 1'b0, 0);

        // Abort after two RUN cycles
        i_add_term1 = 20'hAAAAA;
        i_add_term2 = 20'h55555;
        i_valid     = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("abort_partial_sum", 32'(sum != '0), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n <= NSLICE; n++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(o_valid), 32'd0);
            chk("abort_ready", 32'(o_ready), 32'd1);
        end
        do_op(20'h00003, 20'h00004, 1'b0, 1'b0, 0);

        if (HAS_SUB) begin
            do_op(20'h00007, 20'h00005, 1'b1, 1'b0, 0);
            do_op(20'h00005, 20'h00007, 1'b1, 1'b0, 2);
            do_op(20'h12345, 20'h12345, 1'b1, 1'b0, 0);
            do_op(20'h00007, 20'h00005, 1'b0, 1'b0, 0);
        end

        // Random operations
        for (int t = 0; t < 40; t++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
